spi_shift_engine: RTL and testbench
===================================

# spi_shift_engine

Parametrised SPI master shift engine: serialises a W-bit word on MOSI while capturing MISO, generating SCLK and CS_N internally. Supports all four SPI modes (CPOL/CPHA), MSB- or LSB-first order and run-time frame lengths of 1..W bits. It sits between the SPI core's write/read buffers and the pads, and replaces the fixed 8-bit, mode-0-only shifter.

## Interface
Parameters:
- W, 8, maximum frame width in bits (≥2)
- HALF, 2, SCLK half-period in clk cycles (≥1)
- LW, $clog2(W), width of len field (derived; do not override)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a transfer; accepted only when busy=0
- tx_data  in  W  word to transmit; captured on accepted start
- len  in  LW  frame length minus one (N = len+1); captured on accepted start
- cpol  in  1  SCLK idle level; captured on accepted start
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; captured on accepted start
- lsb_first  in  1  bit order; captured on accepted start
- miso  in  1  serial data in
- sclk  out  1  serial clock
- mosi  out  1  serial data out
- cs_n  out  1  chip select, active low
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- rx_data  out  W  received word, held until the next done

Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- States: IDLE, LEAD, XFER, TRAIL.
- IDLE: cs_n=1, busy=0, mosi=0; sclk follows cpol, registered one cycle. An accepted start latches the configuration and enters LEAD.
- LEAD: lasts HALF cycles. cs_n=0, sclk=cpol_q. mosi presents the first bit.
- XFER: sclk toggles every HALF cycles, 2N toggles in total. Odd toggles are leading edges; even toggles are trailing edges.
  - cpha=0: sample miso at each leading edge; shift mosi to the next bit at each trailing edge except the last.
  - cpha=1: drive the bit at each leading edge; sample at each trailing edge.
- TRAIL: lasts HALF cycles. cs_n=0 and sclk=cpol_q. Then return to IDLE with done=1 for that cycle.
- TX order:
  - MSB-first sends tx_data[N-1] down to tx_data[0].
  - LSB-first sends tx_data[0] up to tx_data[N-1].
- RX mapping: rx_data[N-1:0] holds the received bits and rx_data[W-1:N] is 0.
  - MSB-first: the first received bit lands in rx_data[N-1].
  - LSB-first: the first received bit lands in rx_data[0].
  - rx_data updates only in the done cycle.
- Bit counter is LW+1 bits wide and counts 0..N-1; there is no wrap beyond N.
- A start while busy=1 is ignored. Input changes while busy=1 have no effect.
- A start in the done cycle (state IDLE) is accepted. cs_n is then high for exactly that one cycle.
- Reset at any time: next cycle is IDLE, and the in-flight transfer is discarded without a done pulse.

## Timing
- Reset values: sclk=0, mosi=0, cs_n=1, busy=0, done=0, rx_data=0.
- Start sampled at edge 0:
  - cycle 1: cs_n=0 and busy=1.
  - LEAD: cycles 1..HALF.
  - XFER: cycles HALF+1..(2N+1)·HALF.
  - TRAIL: following HALF cycles.
  - cycle (2N+2)·HALF+1: done=1, busy=0, cs_n=1, rx_data valid.
- Toggle k (k=1..2N) occurs at clock edge HALF·(k+1). miso is sampled at that same clock edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package spi_pkg holds:
  - state enum spi_state_t {IDLE, LEAD, XFER, TRAIL};
  - packed struct spi_cfg_t {cpol, cpha, lsb_first, len};
  - localparam SPI_MIN_HALF = 1.
- Sub-module spi_clk_div: a HALF-cycle counter emitting a one-cycle tick, enabled outside IDLE and cleared on entry to LEAD. The engine toggles sclk on each tick during XFER and advances state on ticks in LEAD/TRAIL.

## Test plan
- Mode 0, W=8, HALF=2, len=7, tx=0xA5, miso loops back mosi → mosi sequence 1,0,1,0,0,1,0,1; rx_data=0xA5; done at cycle 37; sclk idles 0.
- Mode 3, LSB-first, tx=0x3C, miso tied to the inverted 0xC3 pattern → sclk idles 1; mosi sends 0,0,1,1,1,1,0,0; sampling on rising edges; rx_data=0xC3.
- len=2, MSB-first, tx=0xFD, miso=1 constant → exactly 6 sclk toggles; mosi 1,0,1; rx_data=0x07.
- start held high continuously, len=0 → back-to-back frames; cs_n high exactly 1 cycle between frames; start pulses during busy ignored; one done per frame.
- Reset asserted at toggle 5 of a mode-1 frame → next cycle cs_n=1, sclk=0, busy=0, no done pulse; a fresh start completes normally.
- HALF=1, W=16, len=15, tx=0x8001, loopback → rx_data=0x8001; done at cycle 35.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master shift engine.
// The config struct carries len at a fixed maximum width so it is independent of W.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  localparam int SPI_MIN_HALF  = 1;
  localparam int SPI_LEN_MAX_W = 16;

  typedef struct packed {
    logic                     cpol;
    logic                     cpha;
    logic                     lsb_first;
    logic [SPI_LEN_MAX_W-1:0] len;
  } spi_cfg_t;

endpackage

// File: rtl/spi_shift_engine_if.sv
// Host-side request/response bus of the SPI shift engine.
interface spi_shift_engine_if #(
  parameter int W  = 8,
  parameter int LW = $clog2(W)
);
  // start is a request taken on any rising clk edge where busy is low; tx_data,
  // len, cpol, cpha and lsb_first are captured on that edge. done pulses for one
  // cycle when the frame ends and rx_data is valid from that cycle on.
  logic          start;
  logic [W-1:0]  tx_data;
  logic [LW-1:0] len;
  logic          cpol;
  logic          cpha;
  logic          lsb_first;
  logic          busy;
  logic          done;
  logic [W-1:0]  rx_data;

  modport master (
    output start, tx_data, len, cpol, cpha, lsb_first,
    input  busy, done, rx_data
  );

  modport slave (
    input  start, tx_data, len, cpol, cpha, lsb_first,
    output busy, done, rx_data
  );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period counter: emits a one-cycle tick every HALF enabled cycles.
// clr restarts the count so the first tick lands exactly HALF cycles later.
module spi_clk_div #(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(HALF - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: all four CPOL/CPHA modes, MSB/LSB first, frames of
// 1..W bits. All pad and status outputs come straight from flops.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int W    = 8,
  parameter int HALF = 2,
  parameter int LW   = $clog2(W)
) (
  input  logic               clk,
  input  logic               reset,
  spi_shift_engine_if.slave  bus,
  input  logic               miso,
  output logic               sclk,
  output logic               mosi,
  output logic               cs_n,
  output spi_state_t         dbg_state
);

  spi_state_t    state_q, state_d;
  spi_cfg_t      cfg_q;
  logic [W-1:0]  tx_q;
  logic [W-1:0]  rx_acc;
  logic [LW:0]   bit_cnt;
  logic          trailing;
  logic          tick;
  logic          accept;
  logic          last_bit;
  logic [LW-1:0] cur_pos;
  logic [LW-1:0] nxt_pos;
  logic [LW-1:0] first_pos;

  // Word position of the i-th bit on the wire for a frame of n1+1 bits.
  function automatic logic [LW-1:0] bit_pos(input logic lsb, input logic [LW-1:0] n1,
                                            input logic [LW-1:0] i);
    return lsb ? i : n1 - i;
  endfunction

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_bit  = (SPI_LEN_MAX_W'(bit_cnt) == cfg_q.len);
  assign cur_pos   = bit_pos(cfg_q.lsb_first, cfg_q.len[LW-1:0], bit_cnt[LW-1:0]);
  assign nxt_pos   = bit_pos(cfg_q.lsb_first, cfg_q.len[LW-1:0], bit_cnt[LW-1:0] + LW'(1));
  assign first_pos = bit_pos(bus.lsb_first, bus.len, '0);
  assign dbg_state = state_q;

  spi_clk_div #(.HALF(HALF)) u_clk_div (
    .clk   (clk),
    .reset (reset),
    .en    (state_q != IDLE),
    .clr   (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LEAD;
      LEAD:    if (tick) state_d = XFER;
      XFER:    if (tick && trailing && last_bit) state_d = TRAIL;
      TRAIL:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q       <= '0;
      tx_q        <= '0;
      rx_acc      <= '0;
      bit_cnt     <= '0;
      trailing    <= 1'b0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      cs_n        <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rx_data <= '0;
    end else begin
      cs_n     <= (state_d == IDLE);
      bus.busy <= (state_d != IDLE);
      bus.done <= (state_q == TRAIL) && tick;
      case (state_q)
        IDLE: begin
          sclk <= bus.cpol;
          mosi <= 1'b0;
          if (bus.start) begin
            cfg_q    <= '{cpol: bus.cpol, cpha: bus.cpha, lsb_first: bus.lsb_first,
                          len: SPI_LEN_MAX_W'(bus.len)};
            tx_q     <= bus.tx_data;
            rx_acc   <= '0;
            bit_cnt  <= '0;
            trailing <= 1'b0;
            mosi     <= bus.tx_data[first_pos];
          end
        end
        XFER: begin
          if (tick) begin
            sclk     <= ~sclk;
            trailing <= ~trailing;
            if (!trailing) begin
              if (!cfg_q.cpha) rx_acc[cur_pos] <= miso;
              else             mosi <= tx_q[cur_pos];
            end else begin
              if (cfg_q.cpha)     rx_acc[cur_pos] <= miso;
              else if (!last_bit) mosi <= tx_q[nxt_pos];
              // The counter parks on the last bit instead of wrapping.
              if (!last_bit) bit_cnt <= bit_cnt + (LW+1)'(1);
            end
          end
        end
        TRAIL: begin
          if (tick) begin
            bus.rx_data <= rx_acc;
            mosi        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: a cycle-indexed frame model checks every
// output each cycle, and literal expectations from hand-worked frames pin the model.
module tb_spi_shift_engine;
  import spi_pkg::*;

  localparam int H = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_shift_engine_if #(.W(8))  bus ();
  spi_shift_engine_if #(.W(16)) bus16 ();

  logic       miso, sclk, mosi, cs_n;
  logic       miso16, sclk16, mosi16, cs_n16;
  spi_state_t dbg, dbg16;
  int         miso_mode = 0;

  assign miso   = (miso_mode == 0) ? mosi : (miso_mode == 1) ? ~mosi : 1'b1;
  assign miso16 = mosi16;

  spi_shift_engine #(.W(8), .HALF(H)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .miso(miso),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .dbg_state(dbg)
  );

  spi_shift_engine #(.W(16), .HALF(1)) u_dut16 (
    .clk(clk), .reset(reset), .bus(bus16), .miso(miso16),
    .sclk(sclk16), .mosi(mosi16), .cs_n(cs_n16), .dbg_state(dbg16)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural frame model ----------------
  // Tracks edges since the accepting edge; toggle k lands on edge H*(k+1).
  logic       m_valid = 1'b0;
  logic       m_active = 1'b0;
  logic       m_done_cyc = 1'b0;
  int         m_e = 0;
  int         m_n = 1;
  logic       m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;
  logic [7:0] m_tx = '0, m_rx_acc = '0, m_rx = '0;
  logic       m_sclk_idle = 1'b0;
  logic [7:0] exp_q[$];
  int         mk, midx, mpos;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_active = 1'b0;
      m_done_cyc = 1'b0;
      m_rx = '0;
      m_sclk_idle = 1'b0;
    end else if (m_valid) begin
      m_done_cyc = 1'b0;
      if (m_active) begin
        m_e++;
        if ((m_e % H) == 0 && (m_e / H) >= 2 && (m_e / H - 1) <= 2 * m_n) begin
          mk = m_e / H - 1;
          if (((mk % 2) == 1) != m_cpha) begin
            midx = (mk - 1) / 2;
            mpos = m_lsb ? midx : m_n - 1 - midx;
            m_rx_acc[mpos] = miso;
          end
        end
        if (m_e == (2 * m_n + 2) * H) begin
          m_active = 1'b0;
          m_done_cyc = 1'b1;
          m_rx = m_rx_acc;
          m_sclk_idle = m_cpol;
          exp_q.push_back(m_rx_acc);
        end
      end else begin
        m_sclk_idle = bus.cpol;
        if (bus.start) begin
          m_active = 1'b1;
          m_e = 0;
          m_n = int'(bus.len) + 1;
          m_cpol = bus.cpol;
          m_cpha = bus.cpha;
          m_lsb = bus.lsb_first;
          m_tx = bus.tx_data;
          m_rx_acc = '0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int   ct, cidx;
  logic e_sclk, e_mosi, e_cs_n, e_busy, e_done;

  always @(negedge clk) begin
    if (m_valid) begin
      if (m_active) begin
        ct = m_e / H - 1;
        if (ct < 0) ct = 0;
        if (ct > 2 * m_n) ct = 2 * m_n;
        if (m_cpha) begin
          cidx = (ct + 1) / 2 - 1;
          if (cidx < 0) cidx = 0;
        end else begin
          cidx = ct / 2;
          if (cidx > m_n - 1) cidx = m_n - 1;
        end
        e_sclk = m_cpol ^ ct[0];
        e_mosi = m_tx[m_lsb ? cidx : m_n - 1 - cidx];
        e_cs_n = 1'b0;
        e_busy = 1'b1;
        e_done = 1'b0;
      end else begin
        e_sclk = m_sclk_idle;
        e_mosi = 1'b0;
        e_cs_n = 1'b1;
        e_busy = 1'b0;
        e_done = m_done_cyc;
      end
      check("sclk", sclk, e_sclk);
      check("mosi", mosi, e_mosi);
      check("cs_n", cs_n, e_cs_n);
      check("busy", bus.busy, e_busy);
      check("done", bus.done, e_done);
      if (m_done_cyc && exp_q.size() > 0) check("rx_data_q", bus.rx_data, exp_q.pop_front());
      else check("rx_data", bus.rx_data, m_rx);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_frame(input logic cp, input logic ch, input logic lsb,
                           input logic [2:0] ln, input logic [7:0] tx, input int mm,
                           input logic [7:0] exp_rx, input int exp_done,
                           input int exp_tog, input logic [7:0] exp_seq);
    int c, tog;
    logic got, prev;
    logic [7:0] seq;
    @(negedge clk);
    bus.cpol = cp; bus.cpha = ch; bus.lsb_first = lsb;
    bus.len = ln; bus.tx_data = tx; miso_mode = mm; bus.start = 1'b1;
    @(posedge clk);
    c = 0; tog = 0; got = 1'b0; prev = cp; seq = '0;
    while (c < 2000 && !got) begin
      @(negedge clk);
      c++;
      bus.start = 1'b1;          // re-requests while busy must be ignored
      bus.tx_data = ~tx;
      bus.len = ~ln;
      bus.cpol = ~cp;
      if (bus.done) got = 1'b1;
      else if (sclk != prev) begin
        tog++;
        if (sclk != cp) seq = {seq[6:0], mosi};
      end
      prev = sclk;
    end
    bus.start = 1'b0;
    bus.cpol = cp;
    check("frame_done_seen", got, 1);
    check("done_cycle", c, exp_done);
    check("rx_literal", bus.rx_data, exp_rx);
    check("toggle_count", tog, exp_tog);
    check("mosi_sequence", seq, exp_seq);
    check("sclk_idle_level", sclk, cp);
  endtask

  task automatic run_back_to_back();
    int dones, highs, consec;
    logic prev_high;
    @(negedge clk);
    bus.cpol = 0; bus.cpha = 0; bus.lsb_first = 0; bus.len = 3'd0;
    bus.tx_data = 8'h01; miso_mode = 0; bus.start = 1'b1;
    @(posedge clk);
    dones = 0; highs = 0; consec = 0; prev_high = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (cs_n) begin
        highs++;
        if (prev_high) consec++;
      end
      prev_high = cs_n;
      bus.tx_data = 8'(c * 37);
      if (c == 45) bus.start = 1'b0;
    end
    check("b2b_dones", dones, 5);
    check("b2b_cs_high_cycles", highs, 5);
    check("b2b_cs_high_consecutive", consec, 0);
    repeat (12) @(negedge clk);
  endtask

  task automatic run_reset_midframe();
    int dones;
    @(negedge clk);
    bus.cpol = 0; bus.cpha = 1; bus.lsb_first = 0; bus.len = 3'd7;
    bus.tx_data = 8'h96; miso_mode = 0; bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;              // sampled on edge 12, the edge of toggle 5
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_cs_n", cs_n, 1);
    check("rst_mid_sclk", sclk, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_done", bus.done, 0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("rst_mid_no_done", dones, 0);
  endtask

  task automatic run_wide_half1();
    int c, busy_cyc;
    logic got;
    @(negedge clk);
    bus16.cpol = 0; bus16.cpha = 0; bus16.lsb_first = 0; bus16.len = 4'hF;
    bus16.tx_data = 16'h8001; bus16.start = 1'b1;
    @(posedge clk);
    c = 0; busy_cyc = 0; got = 1'b0;
    while (c < 2000 && !got) begin
      @(negedge clk);
      c++;
      bus16.start = 1'b0;
      if (bus16.busy) busy_cyc++;
      if (bus16.done) got = 1'b1;
    end
    check("w16_done_seen", got, 1);
    check("w16_done_cycle", c, 35);
    check("w16_rx", bus16.rx_data, 32'h8001);
    check("w16_busy_cycles", busy_cyc, 34);
    check("w16_cs_n_done", cs_n16, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start = 0; bus.tx_data = '0; bus.len = '0;
    bus.cpol = 0; bus.cpha = 0; bus.lsb_first = 0;
    bus16.start = 0; bus16.tx_data = '0; bus16.len = '0;
    bus16.cpol = 0; bus16.cpha = 0; bus16.lsb_first = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rx", bus.rx_data, 0);
    repeat (3) @(negedge clk);

    // mode 0, MSB first, loopback
    run_frame(0, 0, 0, 3'd7, 8'hA5, 0, 8'hA5, 37, 16, 8'hA5);
    // mode 3, LSB first, inverted loopback
    run_frame(1, 1, 1, 3'd7, 8'h3C, 1, 8'hC3, 37, 16, 8'h3C);
    // 3-bit frame, miso constant 1
    run_frame(0, 0, 0, 3'd2, 8'hFD, 2, 8'h07, 17, 6, 8'h05);
    // mode 1, LSB first, 5-bit frame
    run_frame(0, 1, 1, 3'd4, 8'h13, 0, 8'h13, 25, 10, 8'h19);
    run_back_to_back();
    run_reset_midframe();
    run_frame(0, 1, 0, 3'd7, 8'h5A, 0, 8'h5A, 37, 16, 8'h5A);
    run_wide_half1();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
